ser_shift_ctrl: RTL and testbench
=================================

SER_SHIFT_CTRL -- requirements
Module: ser_shift_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning operand width in bits and serial phase length in cycles; LEN SHALL be a power of two, minimum 4.
REQ-002 SHALL have ports, in order (name  direction  width  meaning):
- i_clk  in  1  single clock; all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_req  in  2  per-requester operation request.
- i_shamt0, i_shamt1  in  log2(LEN)  shift amount, requester 0 and 1.
- i_right  in  2  per-requester shift direction: 1 is right.
- i_signed  in  2  per-requester arithmetic flag.
- i_d0, i_d1  in  1  per-requester serial operand bit, LSB first.
- o_gnt  out  2  one-hot grant.
- o_op_rdy  out  1  granted requester SHALL drive its operand bit this cycle.
- o_sh_load  out  1  load enable to the serial shifter.
- o_sh_d  out  1  serial data to the shifter.
- o_sh_shamt  out  log2(LEN)  shift amount to the shifter.
- o_sh_right, o_sh_signed  out  1  direction and sign mode to the shifter.
- i_sh_q  in  1  shifter serial result.
- o_q  out  1  result bit to the granted requester.
- o_q_vld  out  1  o_q is valid this cycle.
- o_done  out  1  single-cycle pulse on the last result bit.

Function
REQ-003 SHALL implement states IDLE, LOAD and SHIFT, with a log2(LEN)-bit phase counter.
REQ-004 In IDLE, if any i_req bit is 1, the block SHALL select a winner and enter LOAD on the next edge; the counter SHALL be set to 0 on that edge.
REQ-005 Arbitration SHALL be round-robin: if both requesters request, the one that was not granted last wins; if one requests, it wins.
REQ-006 On the IDLE->LOAD edge, the block SHALL register o_gnt, o_sh_shamt, o_sh_right and o_sh_signed from the winner's inputs.
REQ-007 o_gnt and the registered configuration SHALL hold constant through LOAD and SHIFT, because the shifter uses shamt combinationally.
REQ-008 In LOAD, o_sh_load and o_op_rdy SHALL be 1, and o_sh_d SHALL equal the winner's i_dX (combinational mux).
REQ-009 The counter SHALL increment each cycle in LOAD and SHIFT.
- LOAD SHALL end after exactly LEN cycles (counter wraps LEN-1 -> 0).
- The block SHALL then enter SHIFT.
REQ-010 In SHIFT:
- o_sh_load SHALL be 0.
- o_q_vld SHALL be 1.
- o_q SHALL equal i_sh_q combinationally.
- Result bits SHALL be delivered LSB first for exactly LEN cycles.
REQ-011 o_done SHALL be 1 only in the SHIFT cycle with counter = LEN-1.
REQ-012 The block SHALL return to IDLE on the next edge, clear o_gnt, and update the last-granted pointer.
REQ-013 Back-to-back operations SHALL have exactly one IDLE cycle between o_done and the next LOAD cycle; the total is 2*LEN+1 cycles per operation, including the grant cycle.
REQ-014 Changes to i_req, i_shamtX, i_right or i_signed after grant SHALL be ignored until the block returns to IDLE.
- A requester that drops i_req mid-operation still receives its full result.
REQ-015 Outside LOAD, o_op_rdy and o_sh_load SHALL be 0; outside SHIFT, o_q_vld, o_q and o_done SHALL be 0.
- o_sh_d SHALL be 0 outside LOAD.
REQ-016 A new request arriving while the block is not in IDLE SHALL wait; there SHALL be no queueing beyond i_req being held.

Reset
REQ-017 When i_rst_n is low, the block SHALL asynchronously force:
- state to IDLE and counter to 0;
- o_gnt, o_sh_shamt, o_sh_right and o_sh_signed to 0;
- the last-granted pointer to requester 1, so requester 0 wins the first tie.
REQ-018 Reset asserted mid-LOAD or mid-SHIFT SHALL abort the operation with no o_done pulse.
- The first grant after reset release SHALL occur no earlier than the first rising edge with i_rst_n high.

Verification
REQ-019 The bench SHALL cover these directed scenarios (LEN=32, shifter model attached):
- Single request: req0, shamt=4, right=0, operand 0x0000_00FF -> LOAD for 32 cycles, then results LSB first forming 0x0000_0FF0, o_done on bit 31, o_gnt=01 throughout.
- Arithmetic right shift: req1, shamt=8, right=1, signed=1, operand 0x8000_0000 -> result 0xFF80_0000; the same with signed=0 -> 0x0080_0000.
- Tie after reset: both requesting -> grant 01, then 10, then 01; one IDLE cycle between each o_done and the next o_op_rdy.
- shamt=0 with operand 0xA5A5_A5A5 -> result 0xA5A5_A5A5; i_shamt0 changed mid-SHIFT -> result unchanged.
- i_rst_n pulsed low in SHIFT cycle 10 -> all outputs 0 immediately with no o_done; req0 held -> new LOAD begins one cycle after reset release.
- i_req dropped in LOAD cycle 5 -> all 32 result bits and o_done still delivered.

Source files
------------

// File: rtl/ser_shift_ctrl.sv
// Controller that arbitrates two requesters onto one serial shifter.
// Each operation loads LEN operand bits, then returns LEN result bits, LSB first.
module ser_shift_ctrl #(
  parameter int unsigned LEN = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              i_req,
  input  logic [$clog2(LEN)-1:0]  i_shamt0,
  input  logic [$clog2(LEN)-1:0]  i_shamt1,
  input  logic [1:0]              i_right,
  input  logic [1:0]              i_signed,
  input  logic                    i_d0,
  input  logic                    i_d1,
  output logic [1:0]              o_gnt,
  output logic                    o_op_rdy,
  output logic                    o_sh_load,
  output logic                    o_sh_d,
  output logic [$clog2(LEN)-1:0]  o_sh_shamt,
  output logic                    o_sh_right,
  output logic                    o_sh_signed,
  input  logic                    i_sh_q,
  output logic                    o_q,
  output logic                    o_q_vld,
  output logic                    o_done
);

  localparam int unsigned CW = $clog2(LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          win;

  // Round-robin: on a tie the requester not granted last time wins.
  assign win = (i_req == 2'b11) ? ~last : i_req[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_gnt       <= '0;
      o_sh_shamt  <= '0;
      o_sh_right  <= 1'b0;
      o_sh_signed <= 1'b0;
      last        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|i_req) begin
            state       <= LOAD;
            cnt         <= '0;
            o_gnt       <= win ? 2'b10 : 2'b01;
            o_sh_shamt  <= win ? i_shamt1 : i_shamt0;
            o_sh_right  <= i_right[win];
            o_sh_signed <= i_signed[win];
          end
        end
        LOAD: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            o_gnt <= '0;
            last  <= o_gnt[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Phase strobes decode the state register; data paths pass straight through.
  assign o_op_rdy  = (state == LOAD);
  assign o_sh_load = (state == LOAD);
  assign o_sh_d    = (state == LOAD) & (o_gnt[1] ? i_d1 : i_d0);
  assign o_q_vld   = (state == SHIFT);
  assign o_q       = (state == SHIFT) & i_sh_q;
  assign o_done    = (state == SHIFT) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_ser_shift_ctrl.sv
// Bench for ser_shift_ctrl: serial shifter and requester models, scoreboard,
// directed scenarios followed by randomized operations.
module tb_ser_shift_ctrl;

  localparam int unsigned LEN = 32;
  localparam int unsigned CW  = $clog2(LEN);

  typedef struct {
    logic [1:0]     gnt;
    logic [LEN-1:0] res;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [1:0]     req;
  logic [CW-1:0]  sh [2];
  logic [1:0]     rt;
  logic [1:0]     sg;
  logic [LEN-1:0] opw [2];
  logic d0, d1;
  logic [1:0]     o_gnt;
  logic o_op_rdy, o_sh_load, o_sh_d, o_sh_right, o_sh_signed;
  logic [CW-1:0]  o_sh_shamt;
  logic i_sh_q, o_q, o_q_vld, o_done;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  logic m_last = 1'b1;

  ser_shift_ctrl #(.LEN(LEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_shamt0(sh[0]), .i_shamt1(sh[1]), .i_right(rt), .i_signed(sg),
    .i_d0(d0), .i_d1(d1), .o_gnt(o_gnt), .o_op_rdy(o_op_rdy),
    .o_sh_load(o_sh_load), .o_sh_d(o_sh_d), .o_sh_shamt(o_sh_shamt),
    .o_sh_right(o_sh_right), .o_sh_signed(o_sh_signed), .i_sh_q(i_sh_q),
    .o_q(o_q), .o_q_vld(o_q_vld), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result straight from the shift definition.
  function automatic logic [LEN-1:0] ref_res(input logic [LEN-1:0] op, input int s,
                                             input logic r, input logic a);
    if (!r) return op << s;
    if (a) return LEN'($signed(op) >>> s);
    return op >> s;
  endfunction

  // Shifter model: one result bit computed per position from the captured operand.
  function automatic logic sh_bit(input logic [LEN-1:0] v, input int i, input int s,
                                  input logic r, input logic a);
    int src;
    if (!r) begin
      src = i - s;
      return (src >= 0) ? v[src[CW-1:0]] : 1'b0;
    end
    src = i + s;
    if (src < int'(LEN)) return v[src[CW-1:0]];
    return a ? v[LEN-1] : 1'b0;
  endfunction

  logic [LEN-1:0] sh_reg;
  logic [CW-1:0]  ld_idx, q_idx, idx0, idx1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx <= '0;
      q_idx  <= '0;
      sh_reg <= '0;
    end else if (o_gnt == 2'b00) begin
      ld_idx <= '0;
      q_idx  <= '0;
    end else begin
      if (o_sh_load) begin
        sh_reg[ld_idx] <= o_sh_d;
        ld_idx <= ld_idx + CW'(1);
      end
      if (o_q_vld) q_idx <= q_idx + CW'(1);
    end
  end

  assign i_sh_q = sh_bit(sh_reg, int'(q_idx), int'(o_sh_shamt), o_sh_right, o_sh_signed);

  // Requesters present operand bits LSB first while granted and asked.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx0 <= '0;
      idx1 <= '0;
    end else begin
      if (!o_gnt[0]) idx0 <= '0;
      else if (o_op_rdy) idx0 <= idx0 + CW'(1);
      if (!o_gnt[1]) idx1 <= '0;
      else if (o_op_rdy) idx1 <= idx1 + CW'(1);
    end
  end

  assign d0 = opw[0][idx0];
  assign d1 = opw[1][idx1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {o_gnt, o_op_rdy, o_sh_load, o_sh_d, o_sh_shamt, o_sh_right,
            o_sh_signed, o_q, o_q_vld, o_done};
  endfunction

  // Monitor: collects each operation's result bits and compares against the scoreboard.
  initial begin
    int ld_n, q_n;
    logic [LEN-1:0] word;
    logic [1:0] gcap;
    logic gbad, ok, dexp;
    exp_t e;
    ld_n = 0; q_n = 0; word = '0; gcap = '0; gbad = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ld_n = 0; q_n = 0; word = '0; gbad = 1'b0;
      end else begin
        dexp = o_gnt[1] ? d1 : d0;
        ok = (o_sh_load == o_op_rdy) && !(o_op_rdy && o_q_vld) &&
             (o_op_rdy || !o_sh_d) && (o_q_vld || (!o_q && !o_done)) &&
             (!o_op_rdy || (o_sh_d == dexp)) && (!o_q_vld || (o_q == i_sh_q)) &&
             ($countones(o_gnt) <= 1);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL invariant outs=%0h t=%0t", all_outs(), $time);
        end
        if (o_op_rdy) begin
          if (ld_n == 0) gcap = o_gnt;
          ld_n++;
        end
        if ((o_op_rdy || o_q_vld) && (o_gnt != gcap)) gbad = 1'b1;
        if (o_q_vld) begin
          if (q_n < int'(LEN)) word[q_n[CW-1:0]] = o_q;
          q_n++;
        end
        if (o_done) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL spurious_done got=1 exp=0 t=%0t", $time);
          end else begin
            e = sb.pop_front();
            check("result", 64'(word), 64'(e.res));
            check("grant", {62'd0, gcap}, {62'd0, e.gnt});
            check("phase_len", {ld_n, q_n}, {int'(LEN), int'(LEN)});
            check("grant_stable", 64'(gbad), 64'd0);
          end
          ld_n = 0; q_n = 0; word = '0; gbad = 1'b0;
        end
      end
    end
  end

  // One operation from an IDLE cycle; optional drop, config scramble, or reset abort at cycle k.
  task automatic run_one(input int drop_at, input int chg_at, input int rst_at);
    int w;
    exp_t e;
    w = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
    m_last = w[0];
    e.gnt = (w == 1) ? 2'b10 : 2'b01;
    e.res = ref_res(opw[w], int'(sh[w]), rt[w], sg[w]);
    sb.push_back(e);
    for (int k = 0; k < 2 * int'(LEN); k++) begin
      @(posedge clk); #1;
      if (k == 0) check("grant_latency", {61'd0, o_op_rdy, o_gnt}, {61'd0, 1'b1, e.gnt});
      if (k == drop_at) req[w[0]] = 1'b0;
      if (k == chg_at) begin
        sh[w] = CW'($urandom);
        rt    = 2'($urandom);
        sg    = 2'($urandom);
        opw[w] = $urandom;
        req   = 2'($urandom);
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1 check("abort_outs", 64'(all_outs()), 64'd0);
        @(posedge clk); #1;
        check("abort_hold", 64'(all_outs()), 64'd0);
        sb.delete();
        m_last = 1'b1;
        rst_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    check("idle_gap", {61'd0, o_gnt, o_op_rdy}, 64'd0);
  endtask

  task automatic set_cfg(input int r, input logic [LEN-1:0] op, input int s,
                         input logic r_dir, input logic a);
    opw[r] = op;
    sh[r]  = CW'(s);
    rt[r]  = r_dir;
    sg[r]  = a;
  endtask

  initial begin
    int idle, drop, chg;
    rst_n = 1'b0;
    req = '0; rt = '0; sg = '0;
    sh[0] = '0; sh[1] = '0; opw[0] = '0; opw[1] = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_req", 64'(all_outs()), 64'd0);

    set_cfg(0, 32'h0000_00FF, 4, 1'b0, 1'b0);
    req = 2'b01;
    run_one(-1, -1, -1);

    set_cfg(1, 32'h8000_0000, 8, 1'b1, 1'b1);
    req = 2'b10;
    run_one(-1, -1, -1);
    sg[1] = 1'b0;
    run_one(-1, -1, -1);
    req = 2'b00;

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    set_cfg(0, 32'h1234_5678, 3, 1'b1, 1'b1);
    set_cfg(1, 32'h9ABC_DEF0, 5, 1'b0, 1'b0);
    req = 2'b11;
    repeat (3) run_one(-1, -1, -1);
    req = 2'b00;

    set_cfg(0, 32'hA5A5_A5A5, 0, 1'b0, 1'b0);
    req = 2'b01;
    run_one(-1, int'(LEN) + 5, -1);
    req = 2'b00;

    set_cfg(0, 32'hC3C3_0F0F, 7, 1'b1, 1'b1);
    req = 2'b01;
    run_one(-1, -1, int'(LEN) + 10);
    run_one(-1, -1, -1);
    req = 2'b00;

    set_cfg(0, 32'hDEAD_BEEF, 12, 1'b0, 1'b0);
    req = 2'b01;
    run_one(5, -1, -1);
    req = 2'b00;

    repeat (24) begin
      set_cfg(0, $urandom, int'($urandom_range(0, LEN - 1)), 1'($urandom), 1'($urandom));
      set_cfg(1, $urandom, int'($urandom_range(0, LEN - 1)), 1'($urandom), 1'($urandom));
      idle = int'($urandom_range(0, 2));
      repeat (idle) begin
        @(posedge clk); #1;
        check("idle_hold", {62'd0, o_gnt}, 64'd0);
      end
      req  = 2'($urandom_range(1, 3));
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LEN - 1)) : -1;
      chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(LEN, 2 * LEN - 1)) : -1;
      run_one(drop, chg, -1);
      req = 2'b00;
    end

    repeat (4) @(posedge clk);
    #1 check("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
